writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Drives the register file's single write port (WB_ADDRESS / WRITE_ENABLE / WRITE_DATA) from two result producers: the in-order pipeline writeback path and the multi-cycle RV32M mul/div unit.
- Buffers mul/div results in a small FIFO and issues at most one register write per cycle.
- Gives the pipeline priority, with a starvation guard for buffered results.
- Reports read-after-write hazards to decode for destination registers with pending writes.

Parameters:
DATA_WIDTH, 32, register data width
FIFO_DEPTH, 2, mul/div result buffer entries (power of 2, >= 2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before the pipeline is stalled

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
PIPE_VALID  input  1  pipeline result valid this cycle
PIPE_ADDR  input  5  pipeline destination register
PIPE_DATA  input  DATA_WIDTH  pipeline result
PIPE_STALL  output  1  pipeline result not taken this cycle; pipeline holds its result
MD_VALID  input  1  mul/div result valid
MD_ADDR  input  5  mul/div destination register
MD_DATA  input  DATA_WIDTH  mul/div result
MD_READY  output  1  FIFO can accept a mul/div result
QUERY_ADRS1  input  5  decode source register 1
QUERY_ADRS2  input  5  decode source register 2
HAZARD  output  1  a query address has a pending write
WB_ADDRESS  output  5  register file write address
WRITE_ENABLE  output  1  register file write enable
WRITE_DATA  output  DATA_WIDTH  register file write data
PENDING_COUNT  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (RESET low, asynchronous):
  - WRITE_ENABLE = 0, WB_ADDRESS = 0, WRITE_DATA = 0.
  - FIFO emptied; PENDING_COUNT = 0; starvation counter = 0.
  - MD_READY, PIPE_STALL and HAZARD are forced to 0 while RESET is low.
  - Reset mid-operation discards all buffered results.
- Output stage:
  - WB_ADDRESS, WRITE_ENABLE and WRITE_DATA are registered.
  - The winner selected in cycle N appears on the write port in cycle N+1.
  - WRITE_ENABLE falls to 0 on any cycle with no winner.
- MD accept:
  - MD_READY = (PENDING_COUNT < FIFO_DEPTH), combinational.
  - A transfer occurs when MD_VALID && MD_READY.
  - MD_ADDR == 0: the transfer is accepted and the result discarded, not pushed.
  - MD_READY does not consider a same-cycle pop: when full, MD_READY = 0 even if the FIFO pops that cycle.
- Arbitration (per cycle):
  - "Pipe eligible" = PIPE_VALID && PIPE_ADDR != 0.
  - If PIPE_STALL: pop the FIFO head and write it. The pipe result is ignored and the pipeline re-presents it next cycle.
  - Else if pipe eligible: write the pipe result.
  - Else if FIFO non-empty: pop the head and write it.
  - PIPE_VALID with PIPE_ADDR == 0 never writes and does not block a pop.
- Minimum mul/div latency: accepted at edge N, written to the register file at edge N+2, if not blocked by the pipe.
- Simultaneous push and pop: both occur; PENDING_COUNT unchanged. FIFO is strictly in order.
- Starvation guard:
  - The counter increments each cycle the FIFO is non-empty and the head is not popped.
  - It clears on a pop or when the FIFO is empty.
  - PIPE_STALL = (counter == STARVE_LIMIT) && FIFO non-empty, combinational.
  - The counter saturates at STARVE_LIMIT.
- HAZARD (combinational) is 1 if either query address is nonzero and matches either of:
  - the address of any valid FIFO entry;
  - WB_ADDRESS while WRITE_ENABLE = 1 (that write lands at the current edge; the register file read is combinational).
  - Address 0 never raises HAZARD.
- Wrap-around: read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from PENDING_COUNT.

Test Plan:
- Reset release, idle inputs -> WRITE_ENABLE=0, MD_READY=1, PENDING_COUNT=0, HAZARD=0.
- PIPE_VALID, ADDR=5, DATA=0xDEADBEEF at cycle N -> at N+1, WRITE_ENABLE=1, WB_ADDRESS=5, WRITE_DATA=0xDEADBEEF; a query of 5 at N+1 gives HAZARD=1.
- MD pushes to x7=0x11 and x8=0x22 on consecutive cycles, with PIPE_VALID held high (ADDR=3) -> MD_READY=0 after the second push; HAZARD=1 for query 7. After STARVE_LIMIT=4 losing cycles, PIPE_STALL=1 for one cycle, x7=0x11 is written, and the pipe retries.
- FIFO full, pipe idle, MD_VALID high -> one pop per cycle; writes are x7 then x8 in order; MD_READY rises once count < 2.
- PIPE_ADDR=0 with PIPE_VALID, plus MD_ADDR=0 -> no register write ever; the FIFO stays empty; MD_READY stays 1.
- RESET pulled low with 2 entries pending -> WRITE_ENABLE=0 immediately and PENDING_COUNT=0; after release, no stale writes appear.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and a buffered mul/div path.
// Latency: winner chosen in cycle N is on the write port in cycle N+1; mul/div accept-to-write >= 2 edges.
// Backpressure: MD_READY drops when the result buffer is full; PIPE_STALL holds the pipeline when the buffer head starves.
module writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          PIPE_VALID,
   input  logic [4:0]                    PIPE_ADDR,
   input  logic [DATA_WIDTH-1:0]         PIPE_DATA,
   output logic                          PIPE_STALL,
   input  logic                          MD_VALID,
   input  logic [4:0]                    MD_ADDR,
   input  logic [DATA_WIDTH-1:0]         MD_DATA,
   output logic                          MD_READY,
   input  logic [4:0]                    QUERY_ADRS1,
   input  logic [4:0]                    QUERY_ADRS2,
   output logic                          HAZARD,
   output logic [4:0]                    WB_ADDRESS,
   output logic                          WRITE_ENABLE,
   output logic [DATA_WIDTH-1:0]         WRITE_DATA,
   output logic [$clog2(FIFO_DEPTH):0]   PENDING_COUNT
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   // Result buffer storage and bookkeeping
   logic [4:0]            fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [SW-1:0]         starve_q, starve_d;

   // Registered write port
   logic [4:0]            wb_addr_q, wb_addr_d;
   logic                  wb_we_q, wb_we_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

   logic fifo_empty, fifo_full, starved, pipe_elig, pop, push;
   logic hit1, hit2;

   // Arbitration, buffer control and next-state selection
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CW'(FIFO_DEPTH));
      starved    = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;
      pipe_elig  = PIPE_VALID && (PIPE_ADDR != 5'd0);
      // A stalled pipeline forces the head out; otherwise the head only uses idle slots.
      pop        = !fifo_empty && (starved || !pipe_elig);
      // Writes to x0 are accepted but dropped so they never occupy a slot.
      push       = MD_VALID && !fifo_full && (MD_ADDR != 5'd0);

      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + 1'b1;
      end

      wb_we_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (pop) begin
         wb_we_d   = 1'b1;
         wb_addr_d = fifo_addr_q[rd_ptr_q];
         wb_data_d = fifo_data_q[rd_ptr_q];
      end else if (pipe_elig) begin
         wb_we_d   = 1'b1;
         wb_addr_d = PIPE_ADDR;
         wb_data_d = PIPE_DATA;
      end
   end

   // Hazard lookup across occupied buffer slots and the write currently landing
   always_comb begin
      logic [PW-1:0] idx;
      hit1 = wb_we_q && (wb_addr_q == QUERY_ADRS1);
      hit2 = wb_we_q && (wb_addr_q == QUERY_ADRS2);
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         idx = rd_ptr_q + PW'(k);
         if (CW'(k) < count_q) begin
            if (fifo_addr_q[idx] == QUERY_ADRS1) hit1 = 1'b1;
            if (fifo_addr_q[idx] == QUERY_ADRS2) hit2 = 1'b1;
         end
      end
   end

   // Handshake outputs are held low while reset is asserted
   always_comb begin
      MD_READY   = RESET && !fifo_full;
      PIPE_STALL = RESET && starved;
      HAZARD     = RESET && ((hit1 && (QUERY_ADRS1 != 5'd0)) ||
                             (hit2 && (QUERY_ADRS2 != 5'd0)));
   end

   // State update; reset discards every buffered result
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         wb_addr_q <= '0;
         wb_we_q   <= 1'b0;
         wb_data_q <= '0;
      end else begin
         if (push) begin
            fifo_addr_q[wr_ptr_q] <= MD_ADDR;
            fifo_data_q[wr_ptr_q] <= MD_DATA;
         end
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         wb_addr_q <= wb_addr_d;
         wb_we_q   <= wb_we_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign WB_ADDRESS    = wb_addr_q;
   assign WRITE_ENABLE  = wb_we_q;
   assign WRITE_DATA    = wb_data_q;
   assign PENDING_COUNT = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model checked every cycle.
// Latency: model advances on each rising edge; outputs compared on the falling edge.
// Backpressure: model tracks buffer occupancy, starvation and stall from the arbitration rules.
module tb_writeback_arbiter;

   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          PIPE_VALID = 1'b0;
   logic [4:0]    PIPE_ADDR = '0;
   logic [DW-1:0] PIPE_DATA = '0;
   logic          PIPE_STALL;
   logic          MD_VALID = 1'b0;
   logic [4:0]    MD_ADDR = '0;
   logic [DW-1:0] MD_DATA = '0;
   logic          MD_READY;
   logic [4:0]    QUERY_ADRS1 = '0;
   logic [4:0]    QUERY_ADRS2 = '0;
   logic          HAZARD;
   logic [4:0]    WB_ADDRESS;
   logic          WRITE_ENABLE;
   logic [DW-1:0] WRITE_DATA;
   logic [1:0]    PENDING_COUNT;

   int n_cmp = 0;
   int n_bad = 0;

   writeback_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RESET(RESET),
      .PIPE_VALID(PIPE_VALID), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA), .PIPE_STALL(PIPE_STALL),
      .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
      .QUERY_ADRS1(QUERY_ADRS1), .QUERY_ADRS2(QUERY_ADRS2), .HAZARD(HAZARD),
      .WB_ADDRESS(WB_ADDRESS), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_DATA(WRITE_DATA),
      .PENDING_COUNT(PENDING_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]    a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   int            m_starve = 0;
   logic          m_we = 1'b0;
   logic [4:0]    m_addr = '0;
   logic [DW-1:0] m_data = '0;

   function automatic bit m_hz(input logic [4:0] a);
      bit h = 0;
      if (a == 5'd0) return 0;
      foreach (mq[i]) if (mq[i].a == a) h = 1;
      if (m_we && m_addr == a) h = 1;
      return h;
   endfunction

   initial begin
      forever begin
         @(posedge CLK or negedge RESET);
         if (!RESET) begin
            mq.delete();
            m_starve = 0;
            m_we = 1'b0;
            m_addr = '0;
            m_data = '0;
         end else begin
            bit elig, stall, room, take_head, was_empty;
            ent_t e;
            was_empty = (mq.size() == 0);
            elig      = PIPE_VALID && (PIPE_ADDR != 0);
            stall     = (m_starve == LIMIT) && !was_empty;
            room      = (mq.size() < DEPTH);
            take_head = !was_empty && (stall || !elig);
            if (take_head) begin
               e = mq.pop_front();
               m_we = 1'b1; m_addr = e.a; m_data = e.d;
            end else if (elig) begin
               m_we = 1'b1; m_addr = PIPE_ADDR; m_data = PIPE_DATA;
            end else begin
               m_we = 1'b0;
            end
            if (take_head || was_empty) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
            if (MD_VALID && room && MD_ADDR != 0) begin
               e.a = MD_ADDR; e.d = MD_DATA;
               mq.push_back(e);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge CLK);
         chk("write_enable", 32'(WRITE_ENABLE), 32'(m_we));
         if (m_we || !RESET) begin
            chk("wb_address", 32'(WB_ADDRESS), 32'(m_addr));
            chk("write_data", WRITE_DATA, m_data);
         end
         chk("pending_count", 32'(PENDING_COUNT), 32'(mq.size()));
         chk("md_ready", 32'(MD_READY), 32'(RESET && (mq.size() < DEPTH)));
         chk("pipe_stall", 32'(PIPE_STALL), 32'(RESET && (m_starve == LIMIT) && (mq.size() > 0)));
         chk("hazard", 32'(HAZARD), 32'(RESET && (m_hz(QUERY_ADRS1) || m_hz(QUERY_ADRS2))));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic pipe(input logic v, input logic [4:0] a, input logic [DW-1:0] d);
      PIPE_VALID = v; PIPE_ADDR = a; PIPE_DATA = d;
   endtask

   task automatic md(input logic v, input logic [4:0] a, input logic [DW-1:0] d);
      MD_VALID = v; MD_ADDR = a; MD_DATA = d;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("rst_we", 32'(WRITE_ENABLE), 32'd0);
      chk("rst_ready", 32'(MD_READY), 32'd1);
      chk("rst_count", 32'(PENDING_COUNT), 32'd0);
      chk("rst_hazard", 32'(HAZARD), 32'd0);
      cyc();

      // single pipeline write and RAW on the landing write
      pipe(1, 5'd5, 32'hDEADBEEF);
      cyc();
      pipe(0, 5'd0, 32'd0);
      QUERY_ADRS1 = 5'd5;
      #1;
      chk("pipe_we", 32'(WRITE_ENABLE), 32'd1);
      chk("pipe_addr", 32'(WB_ADDRESS), 32'd5);
      chk("pipe_data", WRITE_DATA, 32'hDEADBEEF);
      chk("pipe_hazard", 32'(HAZARD), 32'd1);
      cyc();
      QUERY_ADRS1 = 5'd0;

      // buffer fills behind a busy pipeline until the starvation guard fires
      QUERY_ADRS1 = 5'd7; QUERY_ADRS2 = 5'd8;
      pipe(1, 5'd3, 32'h33);
      md(1, 5'd7, 32'h11);
      cyc();
      md(1, 5'd8, 32'h22);
      cyc();
      md(0, 5'd0, 32'd0);
      #1;
      chk("full_count", 32'(PENDING_COUNT), 32'd2);
      chk("full_ready", 32'(MD_READY), 32'd0);
      chk("full_hazard", 32'(HAZARD), 32'd1);
      chk("full_addr", 32'(WB_ADDRESS), 32'd3);
      cyc(); cyc();
      #1 chk("starve3_stall", 32'(PIPE_STALL), 32'd0);
      cyc();
      #1 chk("starve4_stall", 32'(PIPE_STALL), 32'd1);
      cyc();
      #1;
      chk("starve_pop_addr", 32'(WB_ADDRESS), 32'd7);
      chk("starve_pop_data", WRITE_DATA, 32'h11);
      chk("starve_pop_stall", 32'(PIPE_STALL), 32'd0);
      chk("starve_pop_count", 32'(PENDING_COUNT), 32'd1);
      cyc();
      #1 chk("retry_addr", 32'(WB_ADDRESS), 32'd3);
      pipe(0, 5'd0, 32'd0);
      cyc();
      #1;
      chk("drain_addr", 32'(WB_ADDRESS), 32'd8);
      chk("drain_count", 32'(PENDING_COUNT), 32'd0);

      // full buffer drains in order with simultaneous push
      pipe(1, 5'd3, 32'h33);
      md(1, 5'd7, 32'h11);
      cyc();
      md(1, 5'd8, 32'h22);
      cyc();
      pipe(0, 5'd0, 32'd0);
      md(1, 5'd9, 32'h99);
      #1;
      chk("f2_ready", 32'(MD_READY), 32'd0);
      cyc();
      #1;
      chk("f2_w1_addr", 32'(WB_ADDRESS), 32'd7);
      chk("f2_w1_data", WRITE_DATA, 32'h11);
      chk("f2_ready_up", 32'(MD_READY), 32'd1);
      cyc();
      md(0, 5'd0, 32'd0);
      #1;
      chk("f2_w2_addr", 32'(WB_ADDRESS), 32'd8);
      chk("f2_w2_count", 32'(PENDING_COUNT), 32'd1);
      cyc();
      #1;
      chk("f2_w3_addr", 32'(WB_ADDRESS), 32'd9);
      chk("f2_w3_data", WRITE_DATA, 32'h99);
      cyc();
      #1 chk("f2_idle_we", 32'(WRITE_ENABLE), 32'd0);

      // x0 destinations never write and never occupy the buffer
      QUERY_ADRS1 = 5'd0; QUERY_ADRS2 = 5'd0;
      pipe(1, 5'd0, 32'hAAAA);
      md(1, 5'd0, 32'hBBBB);
      for (int i = 0; i < 4; i++) begin
         cyc();
         #1;
         chk("x0_we", 32'(WRITE_ENABLE), 32'd0);
         chk("x0_count", 32'(PENDING_COUNT), 32'd0);
         chk("x0_ready", 32'(MD_READY), 32'd1);
      end
      pipe(0, 5'd0, 32'd0);
      md(0, 5'd0, 32'd0);

      // reset with two results pending
      QUERY_ADRS1 = 5'd10;
      pipe(1, 5'd3, 32'h33);
      md(1, 5'd10, 32'hA0);
      cyc();
      md(1, 5'd11, 32'hB0);
      cyc();
      md(0, 5'd0, 32'd0);
      pipe(0, 5'd0, 32'd0);
      #1;
      chk("prerst_count", 32'(PENDING_COUNT), 32'd2);
      chk("prerst_hazard", 32'(HAZARD), 32'd1);
      RESET = 1'b0;
      #1;
      chk("midrst_we", 32'(WRITE_ENABLE), 32'd0);
      chk("midrst_count", 32'(PENDING_COUNT), 32'd0);
      chk("midrst_ready", 32'(MD_READY), 32'd0);
      chk("midrst_hazard", 32'(HAZARD), 32'd0);
      cyc();
      RESET = 1'b1;
      #1;
      chk("postrst_ready", 32'(MD_READY), 32'd1);
      chk("postrst_hazard", 32'(HAZARD), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1 chk("postrst_we", 32'(WRITE_ENABLE), 32'd0);
      end
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
